// File: rtl/mil_rx_if.sv
// Bus-side signal bundle of the MIL-STD-1553B word receiver.
// The slave modport is the receiver; the master modport is the driving/observing side.
interface mil_rx_if;
    logic        iEN;
    logic [1:0]  iDI;
    logic [15:0] oDATA;
    logic        oCD;
    logic        oVALID;
    logic        oERR;
    logic [1:0]  oERR_CODE;
    logic        oBUSY;

    modport master (
        output iEN, iDI,
        input  oDATA, oCD, oVALID, oERR, oERR_CODE, oBUSY
    );

    modport slave (
        input  iEN, iDI,
        output oDATA, oCD, oVALID, oERR, oERR_CODE, oBUSY
    );
endinterface

// File: rtl/mil_receiver.sv
// MIL-STD-1553B word receiver: sync detection, Manchester decode of 16 data bits
// plus odd parity, with one-cycle valid/error strobes and a busy flag.
module mil_receiver #(
    parameter int HALF = 8,
    parameter int TOL  = 4
) (
    input logic     iCLK,
    input logic     iRESET,
    mil_rx_if.slave bus
);
    localparam int TW = $clog2(37 * HALF + 1);

    localparam logic [1:0]    L_HIGH     = 2'b10;
    localparam logic [1:0]    L_LOW      = 2'b01;
    localparam logic [5:0]    RUN_MIN    = 6'(3 * HALF - TOL);
    localparam logic [5:0]    RUN_MAX    = 6'(3 * HALF + TOL);
    localparam logic [TW-1:0] T_SYNC2    = TW'(3 * HALF / 2);
    localparam logic [TW-1:0] T_BIT0     = TW'(3 * HALF + HALF / 2);
    localparam logic [TW-1:0] T_TAIL_END = TW'(37 * HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_SYNC2 = 3'd2,
        S_DATA  = 3'd3,
        S_TAIL  = 3'd4
    } state_t;

    function automatic logic lvl_ok(input logic [1:0] l);
        return (l == L_HIGH) || (l == L_LOW);
    endfunction

    function automatic logic odd_parity(input logic [15:0] d, input logic p);
        return ^{d, p};
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]  lvl_q, lvl_d, h1_q, h1_d;
    logic [5:0]  run_q, run_d;
    logic [TW-1:0] t_q, t_d, nxt_q, nxt_d;
    logic [4:0]  k_q, k_d;
    logic        half_q, half_d, cd_type_q, cd_type_d;
    logic [15:0] sr_q, sr_d, data_q, data_d;
    logic        cd_q, cd_d, valid_q, valid_d, err_q, err_d, busy_q, busy_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [1:0]  line_s;
    logic        rx_bit_s;

    assign line_s        = sync2_q;
    assign bus.oDATA     = data_q;
    assign bus.oCD       = cd_q;
    assign bus.oVALID    = valid_q;
    assign bus.oERR      = err_q;
    assign bus.oERR_CODE = err_code_q;
    assign bus.oBUSY     = busy_q;

    // Next-state and output computation for the whole receiver
    always_comb begin
        sync1_d    = bus.iDI;
        sync2_d    = sync1_q;
        state_d    = state_q;
        lvl_d      = lvl_q;
        h1_d       = h1_q;
        run_d      = run_q;
        t_d        = t_q + TW'(1);
        nxt_d      = nxt_q;
        k_d        = k_q;
        half_d     = half_q;
        cd_type_d  = cd_type_q;
        sr_d       = sr_q;
        data_d     = data_q;
        cd_d       = cd_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        busy_d     = busy_q;
        rx_bit_s   = (h1_q == L_HIGH);

        if (!bus.iEN) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lvl_ok(line_s)) begin
                        state_d = S_SYNC;
                        lvl_d   = line_s;
                        run_d   = 6'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SYNC: begin
                    // run_q == 0 marks a fresh start right after a word tail
                    if (!lvl_ok(line_s)) begin
                        state_d = S_IDLE;
                    end else if (run_q == 6'd0) begin
                        lvl_d = line_s;
                        run_d = 6'd1;
                    end else if (line_s == lvl_q) begin
                        run_d = (run_q == 6'h3F) ? run_q : run_q + 6'd1;
                    end else if ((run_q >= RUN_MIN) && (run_q <= RUN_MAX)) begin
                        cd_type_d = (lvl_q == L_LOW);
                        lvl_d     = line_s;
                        t_d       = TW'(1);
                        nxt_d     = T_SYNC2;
                        busy_d    = 1'b1;
                        state_d   = S_SYNC2;
                    end else begin
                        lvl_d = line_s;
                        run_d = 6'd1;
                    end
                end
                S_SYNC2: begin
                    if (t_q == nxt_q) begin
                        if (line_s == lvl_q) begin
                            state_d = S_DATA;
                            nxt_d   = T_BIT0;
                            k_d     = 5'd0;
                            half_d  = 1'b0;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = 2'b11;
                            busy_d     = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        state_d = S_SYNC2;
                    end
                end
                S_DATA: begin
                    if (t_q == nxt_q) begin
                        nxt_d = nxt_q + TW'(HALF);
                        if (!lvl_ok(line_s) || (half_q && (line_s == h1_q))) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                            busy_d     = 1'b0;
                            state_d    = S_IDLE;
                        end else if (!half_q) begin
                            h1_d   = line_s;
                            half_d = 1'b1;
                        end else if (k_q == 5'd16) begin
                            half_d  = 1'b0;
                            data_d  = sr_q;
                            cd_d    = cd_type_q;
                            busy_d  = 1'b0;
                            state_d = S_TAIL;
                            if (odd_parity(sr_q, rx_bit_s)) begin
                                valid_d = 1'b1;
                            end else begin
                                err_d      = 1'b1;
                                err_code_d = 2'b10;
                            end
                        end else begin
                            half_d = 1'b0;
                            sr_d   = {sr_q[14:0], rx_bit_s};
                            k_d    = k_q + 5'd1;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_TAIL: begin
                    if (!lvl_ok(line_s)) begin
                        state_d = S_IDLE;
                    end else if (t_q == T_TAIL_END) begin
                        state_d = S_SYNC;
                        run_d   = 6'd0;
                    end else begin
                        state_d = S_TAIL;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q    <= S_IDLE;
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            lvl_q      <= 2'b00;
            h1_q       <= 2'b00;
            run_q      <= 6'd0;
            t_q        <= '0;
            nxt_q      <= '0;
            k_q        <= 5'd0;
            half_q     <= 1'b0;
            cd_type_q  <= 1'b0;
            sr_q       <= 16'h0000;
            data_q     <= 16'h0000;
            cd_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            h1_q       <= h1_d;
            run_q      <= run_d;
            t_q        <= t_d;
            nxt_q      <= nxt_d;
            k_q        <= k_d;
            half_q     <= half_d;
            cd_type_q  <= cd_type_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            cd_q       <= cd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_mil_receiver.sv
// Directed-vector bench for mil_receiver: a driver pushes expected words into a
// scoreboard queue and a monitor compares whenever a valid or error strobe appears.
module tb_mil_receiver;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mil_rx_if bus();

    mil_receiver #(.HALF(H), .TOL(4)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [15:0] data;
        logic        cd;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_run = 0;
    int          last_busy_len = 0;
    int          last_valid_cyc = 0;
    int          prev_valid_cyc = 0;
    logic        quiet = 1'b0;
    logic        busy_seen = 1'b0;
    logic [15:0] last_data = 16'h0000;
    logic        last_cd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_err, input logic [1:0] code, input logic [15:0] d, input logic cd);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.data   = d;
        e.cd     = cd;
        sb_q.push_back(e);
        if (!(is_err && (code != 2'b10))) begin
            last_data = d;
            last_cd   = cd;
        end
    endtask

    task automatic drv(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.iDI = v;
            @(negedge clk);
        end
    endtask

    function automatic logic [1:0] lv(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Sync (first run of run1 cycles) plus nbits Manchester bits; bad_bit repeats a first half
    task automatic send_word(input logic cd, input logic [15:0] d, input int run1,
                             input logic flip_par, input int bad_bit, input int nbits);
        logic [1:0] f;
        logic       b;
        f = cd ? 2'b01 : 2'b10;
        drv(f, run1);
        drv(~f, 3 * H);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? d[15 - i] : ((~^d) ^ flip_par);
            drv(lv(b), H);
            drv(((i < 16) && (bad_bit == 15 - i)) ? lv(b) : lv(~b), H);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor plus busy-length and valid-spacing bookkeeping
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (quiet && bus.oBUSY) busy_seen = 1'b1;
            if (bus.oBUSY) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (bus.oVALID || bus.oERR) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected no strobe",
                             bus.oVALID, bus.oERR);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_kind", {30'd0, bus.oVALID, bus.oERR},
                          mon_e.is_err ? 32'd1 : 32'd2);
                    if (mon_e.is_err) check("err_code", {30'd0, bus.oERR_CODE}, {30'd0, mon_e.code});
                    check("data", {16'd0, bus.oDATA}, {16'd0, mon_e.data});
                    check("cd", {31'd0, bus.oCD}, {31'd0, mon_e.cd});
                end
                if (bus.oVALID) begin
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end
            end
        end
    end

    initial begin
        bus.iEN = 1'b0;
        bus.iDI = 2'b00;
        repeat (4) @(negedge clk);
        check("rst_data", {16'd0, bus.oDATA}, 32'd0);
        check("rst_busy", {31'd0, bus.oBUSY}, 32'd0);
        check("rst_strobes", {30'd0, bus.oVALID, bus.oERR}, 32'd0);
        rst = 1'b0;
        bus.iEN = 1'b1;
        drv(2'b00, 5);

        // Command word A5A5, parity 1
        push(1'b0, 2'b00, 16'hA5A5, 1'b1);
        send_word(1'b1, 16'hA5A5, 3 * H, 1'b0, -1, 17);
        drv(2'b00, 20);
        check("busy_len", last_busy_len, 35 * H + 3 * H / 2);

        // Data word 0001, parity 0
        push(1'b0, 2'b00, 16'h0001, 1'b0);
        send_word(1'b0, 16'h0001, 3 * H, 1'b0, -1, 17);
        drv(2'b00, 20);

        // Inverted parity
        push(1'b1, 2'b10, 16'h1234, 1'b1);
        send_word(1'b1, 16'h1234, 3 * H, 1'b1, -1, 17);
        drv(2'b00, 20);

        // Manchester violation on bit 7: data stays 1234
        push(1'b1, 2'b01, last_data, last_cd);
        send_word(1'b0, 16'hFFFF, 3 * H, 1'b0, 7, 17);
        drv(2'b00, 20);

        // Sync first run too short: nothing at all
        quiet = 1'b1;
        drv(2'b01, 16);
        drv(2'b10, 3 * H);
        drv(2'b00, 20);
        quiet = 1'b0;
        check("short_sync_busy", {31'd0, busy_seen}, 32'd0);

        // Sync first run at both tolerance limits
        push(1'b0, 2'b00, 16'h5A3C, 1'b0);
        send_word(1'b0, 16'h5A3C, 20, 1'b0, -1, 17);
        drv(2'b00, 20);
        push(1'b0, 2'b00, 16'hC3E1, 1'b1);
        send_word(1'b1, 16'hC3E1, 28, 1'b0, -1, 17);
        drv(2'b00, 20);

        // Sync second half reverts early
        push(1'b1, 2'b11, last_data, last_cd);
        drv(2'b01, 3 * H);
        drv(2'b10, 10);
        drv(2'b01, 14);
        drv(2'b00, 20);

        // Back-to-back words with no gap
        push(1'b0, 2'b00, 16'h0C21, 1'b1);
        push(1'b0, 2'b00, 16'hBEEF, 1'b0);
        send_word(1'b1, 16'h0C21, 3 * H, 1'b0, -1, 17);
        send_word(1'b0, 16'hBEEF, 3 * H, 1'b0, -1, 17);
        drv(2'b00, 20);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 40 * H);

        // Reset in the middle of a third word
        send_word(1'b1, 16'h7777, 3 * H, 1'b0, -1, 5);
        check("busy_before_rst", {31'd0, bus.oBUSY}, 32'd1);
        rst = 1'b1;
        drv(2'b00, 3);
        check("midrst_data", {16'd0, bus.oDATA}, 32'd0);
        check("midrst_cd", {31'd0, bus.oCD}, 32'd0);
        check("midrst_busy", {31'd0, bus.oBUSY}, 32'd0);
        check("midrst_code", {30'd0, bus.oERR_CODE}, 32'd0);
        check("midrst_strobes", {30'd0, bus.oVALID, bus.oERR}, 32'd0);
        rst = 1'b0;
        drv(2'b00, 10);

        push(1'b0, 2'b00, 16'h8001, 1'b1);
        send_word(1'b1, 16'h8001, 3 * H, 1'b0, -1, 17);
        drv(2'b00, 20);

        for (int i = 0; (i < 2000) && (sb_q.size() != 0); i++) @(negedge clk);
        check("pending_words", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
